// File: rtl/des_round_ctrl_if.sv
// Handshake and datapath bundle between des_round_ctrl and the surrounding IP/PC-2/f/FP logic.
// The master side offers blocks and supplies f_result; the slave side is the round sequencer.
interface des_round_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] ip_data;
    logic [55:0] key_pc1;
    logic        decrypt;
    logic [31:0] f_r;
    logic [55:0] f_cd;
    logic [31:0] f_result;
    logic [3:0]  round;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] preoutput;

    modport master (
        output in_valid, ip_data, key_pc1, decrypt, f_result, out_ready,
        input  in_ready, f_r, f_cd, round, busy, out_valid, preoutput
    );

    modport slave (
        input  in_valid, ip_data, key_pc1, decrypt, f_result, out_ready,
        output in_ready, f_r, f_cd, round, busy, out_valid, preoutput
    );
endinterface

// File: rtl/des_round_ctrl.sv
// Iterative DES round sequencer: one Feistel round per clock, C/D key schedule held locally.
// Define DES_ROUND_CTRL_DECRYPT_EN to honour the decrypt input (right-rotate key schedule).
module des_round_ctrl #(
    parameter int unsigned NROUNDS = 16
) (
    input logic              clk,
    input logic              rst,
    des_round_ctrl_if.slave  bus_io
);

    localparam logic [3:0] LastCnt = 4'(NROUNDS - 1);

    typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

    state_e      state_q;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic [3:0]  cnt_q;

    logic [27:0] c_src, d_src, c_d, d_d;
    logic [3:0]  sched_idx;

    // Index-level left rotate: X'[i] = X[i+s], i.e. DES bit 2 moves to DES bit 1.
    function automatic logic [27:0] rot_left(input logic [27:0] x, input logic [1:0] s);
        case (s)
            2'd0:    return x;
            2'd1:    return {x[0], x[27:1]};
            default: return {x[1:0], x[27:2]};
        endcase
    endfunction

    function automatic logic [1:0] enc_shift(input logic [3:0] k);
        if (k == 4'd0 || k == 4'd1 || k == 4'd8 || k == 4'd15) return 2'd1;
        return 2'd2;
    endfunction

`ifdef DES_ROUND_CTRL_DECRYPT_EN
    logic mode_q;
    logic sched_dec;

    function automatic logic [27:0] rot_right(input logic [27:0] x, input logic [1:0] s);
        case (s)
            2'd0:    return x;
            2'd1:    return {x[26:0], x[27]};
            default: return {x[25:0], x[27:26]};
        endcase
    endfunction

    // First decrypt round uses K16, which equals the unrotated C0/D0.
    function automatic logic [1:0] dec_shift(input logic [3:0] k);
        if (k == 4'd0) return 2'd0;
        if (k == 4'd1 || k == 4'd8 || k == 4'd15) return 2'd1;
        return 2'd2;
    endfunction
`else
    logic unused_decrypt;
    assign unused_decrypt = bus_io.decrypt;
`endif

    always_comb begin
        c_src     = (state_q == StIdle) ? bus_io.key_pc1[27:0]  : c_q;
        d_src     = (state_q == StIdle) ? bus_io.key_pc1[55:28] : d_q;
        sched_idx = (state_q == StIdle) ? 4'd0 : cnt_q + 4'd1;
`ifdef DES_ROUND_CTRL_DECRYPT_EN
        sched_dec = (state_q == StIdle) ? bus_io.decrypt : mode_q;
        if (sched_dec) begin
            c_d = rot_right(c_src, dec_shift(sched_idx));
            d_d = rot_right(d_src, dec_shift(sched_idx));
        end else begin
            c_d = rot_left(c_src, enc_shift(sched_idx));
            d_d = rot_left(d_src, enc_shift(sched_idx));
        end
`else
        c_d = rot_left(c_src, enc_shift(sched_idx));
        d_d = rot_left(d_src, enc_shift(sched_idx));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
`ifdef DES_ROUND_CTRL_DECRYPT_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.in_valid) begin
                        l_q     <= bus_io.ip_data[31:0];
                        r_q     <= bus_io.ip_data[63:32];
                        c_q     <= c_d;
                        d_q     <= d_d;
                        cnt_q   <= '0;
`ifdef DES_ROUND_CTRL_DECRYPT_EN
                        mode_q  <= bus_io.decrypt;
`endif
                        state_q <= StRound;
                    end
                end
                StRound: begin
                    l_q <= r_q;
                    r_q <= l_q ^ bus_io.f_result;
                    if (cnt_q == LastCnt) begin
                        state_q <= StDone;
                    end else begin
                        c_q   <= c_d;
                        d_q   <= d_d;
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StDone: begin
                    if (bus_io.out_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.in_ready  = (state_q == StIdle);
    assign bus_io.busy      = (state_q == StRound);
    assign bus_io.out_valid = (state_q == StDone);
    assign bus_io.round     = (state_q == StRound) ? cnt_q : 4'd0;
    assign bus_io.f_r       = r_q;
    assign bus_io.f_cd      = {d_q, c_q};
    assign bus_io.preoutput = {l_q, r_q};

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: wraps the sequencer with reference IP/PC-1/PC-2/f/FP models
// and checks ciphertexts, latency, handshake behaviour and asynchronous reset.
module tb_des_round_ctrl;

    logic clk = 1'b0;
    logic rst;

    des_round_ctrl_if bus ();

    des_round_ctrl #(.NROUNDS(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int SBOX [512] = '{
        14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
        15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
        3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
        10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
        7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
        12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
        4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
        4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
        6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
        13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
        1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
        2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

    // Hex vectors are DES-order (bit 1 = MSB); the DUT packs DES bit i+1 at index i.
    function automatic logic [63:0] rev64(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[i] = x[63-i];
        return y;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[i] = x[31-i];
        return y;
    endfunction

    function automatic logic [27:0] rev28(input logic [27:0] x);
        logic [27:0] y;
        for (int i = 0; i < 28; i++) y[i] = x[27-i];
        return y;
    endfunction

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[j] = x[IP_T[j]-1];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[IP_T[j]-1] = x[j];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        for (int j = 0; j < 56; j++) y[j] = x[PC1_T[j]-1];
        return y;
    endfunction

    function automatic logic [31:0] f_model(input logic [31:0] r, input logic [55:0] cd);
        logic [47:0] k, e, x;
        logic [31:0] s, p;
        int row, col, v;
        for (int j = 0; j < 48; j++) k[j] = cd[PC2_T[j]-1];
        for (int b = 0; b < 8; b++)
            for (int q = 0; q < 6; q++) e[6*b+q] = r[(4*b+q+31)%32];
        x = e ^ k;
        for (int b = 0; b < 8; b++) begin
            row = 2 * int'(x[6*b]) + int'(x[6*b+5]);
            col = 8 * int'(x[6*b+1]) + 4 * int'(x[6*b+2]) + 2 * int'(x[6*b+3])
                + int'(x[6*b+4]);
            v = SBOX[b*64 + row*16 + col];
            s[4*b]   = v[3];
            s[4*b+1] = v[2];
            s[4*b+2] = v[1];
            s[4*b+3] = v[0];
        end
        for (int j = 0; j < 32; j++) p[j] = s[P_T[j]-1];
        return p;
    endfunction

    function automatic logic [27:0] sw_rotl(input logic [27:0] x, input int s);
        logic [27:0] y;
        for (int i = 0; i < 28; i++) y[i] = x[(i+s)%28];
        return y;
    endfunction

    // Textbook DES: left-shift key schedule, subkeys reversed for decryption.
    function automatic logic [63:0] sw_des(input logic [63:0] key, input logic [63:0] data,
                                           input logic dec);
        logic [55:0] kp;
        logic [55:0] ks [16];
        logic [27:0] c, d;
        logic [63:0] blk;
        logic [31:0] l, r, t;
        kp = pc1_perm(rev64(key));
        c  = kp[27:0];
        d  = kp[55:28];
        for (int i = 0; i < 16; i++) begin
            c     = sw_rotl(c, SHIFTS[i]);
            d     = sw_rotl(d, SHIFTS[i]);
            ks[i] = {d, c};
        end
        blk = ip_perm(rev64(data));
        l   = blk[31:0];
        r   = blk[63:32];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ f_model(r, dec ? ks[15-i] : ks[i]);
            l = t;
        end
        return rev64(fp_perm({l, r}));
    endfunction

    always_comb bus.f_result = f_model(bus.f_r, bus.f_cd);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [63:0] key, input logic [63:0] data, input logic dec);
        int n;
        bus.key_pc1  = pc1_perm(rev64(key));
        bus.ip_data  = ip_perm(rev64(data));
        bus.decrypt  = dec;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            tick();
            n++;
        end
        if (!bus.in_ready) chk("start_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    typedef struct packed {
        logic [63:0] key;
        logic [63:0] data;
        logic        dec;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          na;
        int          acc [3];
        logic [63:0] snap;
        logic        seen;

        vecs[0] = '{64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405};
        vecs[2] = '{64'h0000000000000000, 64'h0000000000000000, 1'b0, 64'h8CA64DE9C1B123A7};
        vecs[3] = '{64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000};
`ifdef DES_ROUND_CTRL_DECRYPT_EN
        vecs[1] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF};
        vecs[4] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 1'b1, 64'h8787878787878787};
`else
        vecs[1] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1,
                    sw_des(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b0)};
        vecs[4] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 1'b1,
                    sw_des(64'h0E329232EA6D0D73, 64'h0000000000000000, 1'b0)};
`endif

        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.ip_data   = '0;
        bus.key_pc1   = '0;
        bus.decrypt   = 1'b0;
        bus.out_ready = 1'b0;
        #2 rst = 1'b1;
        #10;
        chk("reset_flags", 64'({bus.in_ready, bus.busy, bus.out_valid, bus.round}), 64'h40);
        chk("reset_preoutput", bus.preoutput, 64'd0);
        chk("reset_f_r", 64'(bus.f_r), 64'd0);
        chk("reset_f_cd", 64'(bus.f_cd), 64'd0);
        @(negedge clk) rst = 1'b0;
        tick();

        // Round-1 state of the textbook example.
        start(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0);
        chk("r1_cd", 64'(bus.f_cd), 64'({rev28(28'hAACCF1E), rev28(28'hE19955F)}));
        chk("r1_lr", bus.preoutput, {rev32(32'hCC00CCFF), rev32(32'hF0AAF0AA)});
        chk("r1_flags", 64'({bus.in_ready, bus.busy, bus.out_valid, bus.round}), 64'h20);
        tick();
        chk("r1_r", 64'(bus.f_r), 64'(rev32(32'hEF4A6544)));
        chk("r1_round", 64'(bus.round), 64'd1);
        wait_done(lat);
        handshake();

        for (int i = 0; i < 5; i++) begin
            start(vecs[i].key, vecs[i].data, vecs[i].dec);
            wait_done(lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd16);
            chk($sformatf("vec%0d_ct", i), rev64(fp_perm(bus.preoutput)), vecs[i].exp);
            handshake();
            chk($sformatf("vec%0d_ready", i), 64'({bus.in_ready, bus.out_valid}), 64'h2);
        end

        // Backpressure: DONE holds, in_valid pulses ignored, no accept on the release edge.
        start(64'h0, 64'h0, 1'b0);
        wait_done(lat);
        snap = bus.preoutput;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.ip_data  = {$urandom, $urandom};
            tick();
            chk("bp_hold", bus.preoutput, snap);
            chk("bp_flags", 64'({bus.in_ready, bus.out_valid}), 64'h1);
        end
        bus.in_valid = 1'b1;
        handshake();
        bus.in_valid = 1'b0;
        chk("bp_release", 64'({bus.in_ready, bus.busy, bus.out_valid}), 64'h4);
        chk("bp_ct", rev64(fp_perm(snap)), 64'h8CA64DE9C1B123A7);

        // Asynchronous reset while round 7 is active.
        start(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0);
        lat = 0;
        while (bus.round != 4'd6 && lat < 40) begin
            tick();
            lat++;
        end
        chk("rst_reach_round7", 64'(bus.round), 64'd6);
        #2 rst = 1'b1;
        #1;
        chk("rst_flags", 64'({bus.in_ready, bus.busy, bus.out_valid, bus.round}), 64'h40);
        chk("rst_preoutput", bus.preoutput, 64'd0);
        chk("rst_f_cd", 64'(bus.f_cd), 64'd0);
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        chk("rst_no_out", 64'(seen), 64'd0);
        start(64'h0, 64'h0, 1'b0);
        wait_done(lat);
        chk("rst_next_latency", 64'(lat), 64'd16);
        chk("rst_next_ct", rev64(fp_perm(bus.preoutput)), 64'h8CA64DE9C1B123A7);
        handshake();

        // Back-to-back with in_valid and out_ready held high.
        bus.key_pc1   = pc1_perm(rev64(64'h133457799BBCDFF1));
        bus.ip_data   = ip_perm(rev64(64'h0123456789ABCDEF));
        bus.decrypt   = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        na = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus.in_ready && na < 3) begin
                acc[na] = cyc;
                na++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        chk("b2b_count", 64'(na), 64'd3);
        if (na == 3) begin
            chk("b2b_gap1", 64'(acc[1] - acc[0]), 64'd18);
            chk("b2b_gap2", 64'(acc[2] - acc[1]), 64'd18);
        end
        lat = 0;
        while (!bus.in_ready && lat < 40) begin
            tick();
            lat++;
        end
        bus.out_ready = 1'b0;
        chk("b2b_drain", 64'(bus.in_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/des_round_ctrl.md
# des_round_ctrl

Sequencer for the iterative DES datapath. It accepts an initial-permuted 64-bit block and a PC-1-permuted 56-bit key, then runs 16 Feistel rounds at one round per clock. The external PC-2/f-function logic is driven with the live R half and C/D key state, and the result is folded back each round. The block presents the swapped pre-output block to the final permutation stage behind a valid/ready handshake.

## Interface
Parameters:
- NROUNDS, 16, round count; fixed at 16 for DES, other values unsupported.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  block/key offer.
- in_ready  out  1  high only in IDLE.
- ip_data  in  64  IP output; bit i = DES bit i+1; L0 = [31:0], R0 = [63:32].
- key_pc1  in  56  PC-1 output; C0 = [27:0], D0 = [55:28]; bit i = DES bit i+1.
- decrypt  in  1  mode, sampled at accept; see Configuration.
- f_r  out  32  current R half to the f-function.
- f_cd  out  56  current {D,C} to PC-2, same packing as key_pc1.
- f_result  in  32  combinational f(R, PC-2(CD)), valid in the same cycle.
- round  out  4  active round minus 1 (0..15); 0 outside ROUND.
- busy  out  1  high in ROUND.
- out_valid  out  1  high in DONE.
- out_ready  in  1  consumer accept.
- preoutput  out  64  {L16, R16}: [31:0] = R16, [63:32] = L16; feeds the final permutation.

## Operation
- States: IDLE, ROUND, DONE.
- Registers: L, R (32 each), C, D (28 each), cnt (4), mode.
- Rotation rules, in index terms:
  - Left rotate by s: X'[i] = X[(i+s) mod 28].
  - Right rotate by s: X'[i] = X[(i-s+28) mod 28].
- Encrypt schedule: S = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Decrypt schedule: T = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- IDLE, on in_valid && in_ready:
  - L <= ip_data[31:0], R <= ip_data[63:32].
  - mode <= decrypt.
  - Encrypt: C, D <= left-rotate by S[0]. Decrypt: C, D <= right-rotate by T[0].
  - cnt <= 0, go to ROUND.
- ROUND, each edge:
  - L <= R, R <= L ^ f_result.
  - If cnt < 15: C, D rotated by S[cnt+1] (left) or T[cnt+1] (right); cnt <= cnt + 1.
  - If cnt == 15: C, D unchanged, go to DONE.
- DONE:
  - preoutput = {L, R} swapped per the port packing; held stable.
  - On out_ready, go to IDLE.
- Combinational outputs:
  - f_r = R, f_cd = {D, C}.
  - preoutput = {L, R} in all states; only meaningful when out_valid.
- in_valid is ignored outside IDLE. Inputs are sampled only at the accept edge; later changes have no effect.

## Timing
- Reset values: state = IDLE, all registers 0.
  - Outputs: in_ready = 1, busy = 0, out_valid = 0, round = 0, preoutput = 0, f_r = 0, f_cd = 0.
- Latency: if accepted at edge 0, round k updates at edge k (1..16), and out_valid rises after edge 16 (16 cycles).
- Throughput: 18 cycles per block minimum (accept, 16 rounds, DONE with out_ready = 1).
  - in_ready reasserts the cycle after the DONE handshake.
  - No accept during DONE, even with out_ready high in the same cycle.
- Backpressure: out_ready low holds DONE indefinitely with preoutput stable.
- Reset mid-ROUND or mid-DONE: immediate return to reset values; the in-flight block is discarded and no out_valid is produced.
- f_result must settle within one cycle of f_r/f_cd changing; there is no wait state.

## Configuration
- DES_ROUND_CTRL_DECRYPT_EN defined: decrypt is honoured at accept; decrypt = 1 selects the right-rotate schedule T.
- Undefined: decrypt is ignored, mode is forced to 0, and only schedule S and its logic are built. The decrypt port remains for pin compatibility.

## Test plan
The bench wraps the block with reference IP, PC-1, PC-2, f and final-permutation models, and bit-reverses hex vectors to match the bit i = DES bit i+1 packing.

- Round-1 state: key 133457799BBCDFF1, PT 0123456789ABCDEF -> at accept, C = F0CCAAF rotated to E19955F, D = AACCF1E, L0 = CC00CCFF, R0 = F0AAF0AA; after edge 1, R = EF4A6544.
- Full encrypt: same vector -> out_valid exactly 16 cycles after accept; ciphertext 85E813540F0AB405.
- Decrypt (macro on): CT 85E813540F0AB405 with the same key, decrypt = 1 -> 0123456789ABCDEF. With the macro off, the same stimulus yields encryption of that CT.
- Backpressure: hold out_ready = 0 for 10 cycles -> preoutput stable, in_ready = 0, then a single handshake; in_valid pulses during the hold are not accepted.
- Reset at round 7: assert rst -> all outputs take reset values asynchronously; the next block (key 0, PT 0) completes correctly to 8CA64DE9C1B123A7.
- Back-to-back: in_valid held high with out_ready = 1 -> accepts spaced exactly 18 cycles apart.
